// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/op types and owner-index sizing for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
  function automatic int owner_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, searching upward from ptr_i and wrapping
module rr_picker import mem_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int W = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [W-1:0]       ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [W-1:0]       idx_o,
  output logic               any_o
);
  logic [W-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[j]) begin
        idx_o = j;
        gnt_o = NUM_REQ'(1) << j;
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory read/write port among NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that completes a stalled access with rsp_err.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ-1:0]            rsp_ack,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [owner_w(NUM_REQ)-1:0]   owner,
  output logic                          mem_read_req,
  output logic [ADDR_WIDTH-1:0]         mem_read_addr,
  input  logic                          mem_read_valid,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  output logic                          mem_write_req,
  output logic [ADDR_WIDTH-1:0]         mem_write_addr,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  input  logic                          mem_write_ack
);
  localparam int W = owner_w(NUM_REQ);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [W-1:0] ptr_q, ptr_d, owner_q, owner_d, idx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d, rsp_ack_q, rsp_ack_d, gnt, onehot;
  logic err_q, err_d, busy_q, busy_d, any, tmo, done;

  rr_picker #(.NUM_REQ(NUM_REQ), .W(W)) u_pick (
    .req_i(req_rd | req_wr), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(idx), .any_o(any)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == RD || state_q == WR) ? cnt_q + 1'b1 : '0;
  assign tmo = (state_q == RD || state_q == WR) && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif

  assign done = (state_q == RD && mem_read_valid) || (state_q == WR && mem_write_ack) || tmo;
  assign onehot = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    op_d = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ack_d = rsp_ack_q;
    rdata_d = rdata_q;
    err_d = err_q;
    busy_d = busy_q;
    unique case (state_q)
      IDLE: if (any) begin
        owner_d = idx;
        addr_d = req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = req_wdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
        op_d = |(req_wr & gnt) ? OP_WR : OP_RD;
        state_d = (op_d == OP_WR) ? WR : RD;
        busy_d = 1'b1;
      end
      RD, WR: if (done) begin
        // a real valid/ack beats a watchdog expiry on the same cycle
        rsp_valid_d = (op_q == OP_RD) ? onehot : '0;
        rsp_ack_d = (op_q == OP_WR) ? onehot : '0;
        rdata_d = (op_q == OP_RD) ? (mem_read_valid ? mem_read_data : '0) : rdata_q;
        err_d = (op_q == OP_RD) ? !mem_read_valid : !mem_write_ack;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_d = '0;
        rsp_ack_d = '0;
        err_d = 1'b0;
        busy_d = 1'b0;
        ptr_d = (owner_q == W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      op_q <= OP_RD;
      rsp_valid_q <= '0;
      rsp_ack_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      op_q <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ack_q <= rsp_ack_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end

  assign mem_read_req = state_q == RD;
  assign mem_write_req = state_q == WR;
  assign mem_read_addr = addr_q;
  assign mem_write_addr = addr_q;
  assign mem_write_data = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ack = rsp_ack_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign busy = busy_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized check of mem_port_arbiter against a transaction-level round-robin model
module tb_mem_port_arbiter;
  localparam int N = 4, AW = 32, DW = 32;
  logic clk = 1'b0, rstn = 1'b0;
  logic [N-1:0] req_rd = '0, req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] rsp_valid, rsp_ack;
  logic [DW-1:0] rsp_rdata;
  logic rsp_err, busy;
  logic [1:0] owner;
  logic mem_read_req, mem_write_req;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic mem_read_valid = 1'b0, mem_write_ack = 1'b0;
  logic [DW-1:0] mem_read_data = '0, mem_write_data;
  int tests = 0, fails = 0, ptr = 0, w;
  logic [DW-1:0] last_rdata = '0;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rstn(rstn), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .owner(owner), .mem_read_req(mem_read_req),
    .mem_read_addr(mem_read_addr), .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data),
    .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_ack(mem_write_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(input logic [N-1:0] cand, input int p);
    for (int k = 0; k < N; k++)
      if (cand[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd[i] = rd;
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic run_txn(input int lat, input bit stale, input logic [DW-1:0] rd, output int win);
    bit wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    win = pick(req_rd | req_wr, ptr);
    if (win < 0) begin
      check("no_candidate", 1, 0);
      return;
    end
    wr = req_wr[win];
    a = req_addr[win*AW +: AW];
    d = req_wdata[win*DW +: DW];
    step();
    check("grant_owner", owner, win);
    check("grant_busy", busy, 1);
    check("grant_mem_rd_req", mem_read_req, !wr);
    check("grant_mem_wr_req", mem_write_req, wr);
    check("grant_addr", wr ? mem_write_addr : mem_read_addr, a);
    if (wr) check("grant_wdata", mem_write_data, d);
    for (int c = 0; c < lat; c++) begin
      req_addr[win*AW +: AW] = $urandom;
      step();
      check("hold_req", wr ? mem_write_req : mem_read_req, 1);
      check("hold_addr", wr ? mem_write_addr : mem_read_addr, a);
      check("hold_no_rsp", rsp_valid | rsp_ack, 0);
    end
    if (wr) mem_write_ack = 1'b1;
    else begin
      mem_read_valid = 1'b1;
      mem_read_data = rd;
    end
    step();
    mem_read_valid = 1'b0;
    mem_write_ack = 1'b0;
    mem_read_data = $urandom;
    if (!wr) last_rdata = rd;
    check("done_req_drop", {mem_read_req, mem_write_req}, 0);
    check("done_rsp_valid", rsp_valid, wr ? 0 : (1 << win));
    check("done_rsp_ack", rsp_ack, wr ? (1 << win) : 0);
    check("done_rdata", rsp_rdata, last_rdata);
    check("done_err", rsp_err, 0);
    check("done_busy", busy, 1);
    if (!stale) begin
      req_rd[win] = 1'b0;
      req_wr[win] = 1'b0;
    end
    step();
    check("resp_clear", rsp_valid | rsp_ack, 0);
    check("resp_busy", busy, 0);
    check("resp_owner_hold", owner, win);
    check("resp_rdata_hold", rsp_rdata, last_rdata);
    ptr = (win + 1) % N;
  endtask

  initial begin
    step();
    check("rst_outputs", {rsp_valid, rsp_ack, rsp_err, busy, owner, mem_read_req, mem_write_req}, 0);
    check("rst_addr_data", {mem_read_addr, mem_write_addr, mem_write_data, rsp_rdata}, 0);
    rstn = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(32'h1000 + i), '0);
    for (int k = 0; k < 5; k++) begin
      run_txn(1, 1, $urandom, w);
      check("rr_order", w, rr_exp[k]);
    end
    req_rd = '0;
    set_req(1, 1, 1, 32'h0000_0200, 32'h5555_AAAA);
    set_req(3, 1, 0, 32'h0000_0300, '0);
    run_txn(1, 1, $urandom, w);
    check("rdwr_first_owner", w, 1);
    run_txn(1, 0, $urandom, w);
    check("stale_after_others", w, 3);
    run_txn(1, 0, $urandom, w);
    check("stale_regrant", w, 1);
    set_req(2, 1, 0, 32'h0000_0040, '0);
    run_txn(3, 0, 32'hDEAD_BEEF, w);
    check("single_read_owner", w, 2);
    set_req(0, 0, 1, 32'h0000_0100, 32'h0000_1234);
    run_txn(2, 0, $urandom, w);
    check("write_owner", w, 0);
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < N; i++)
        if (!(req_rd[i] | req_wr[i]) && $urandom_range(0, 2) == 0) begin
          int op = $urandom_range(0, 2);
          set_req(i, op != 1, op != 0, $urandom, $urandom);
        end
      if ((req_rd | req_wr) == '0) begin
        mem_read_valid = 1'b1;
        mem_write_ack = 1'b1;
        mem_read_data = $urandom;
        step();
        mem_read_valid = 1'b0;
        mem_write_ack = 1'b0;
        check("idle_ignore", {busy, mem_read_req, mem_write_req, rsp_valid, rsp_ack}, 0);
        check("idle_rdata_hold", rsp_rdata, last_rdata);
      end else run_txn($urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom, w);
    end
    req_rd = '0;
    req_wr = '0;
    w = pick(4'b0100, ptr);
    set_req(2, 1, 0, 32'h0000_0080, '0);
    step();
    check("rst_mid_in_rd", mem_read_req, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_outputs", {mem_read_req, mem_write_req, busy, rsp_valid, rsp_ack, rsp_err}, 0);
    req_rd = '0;
    set_req(0, 1, 0, 32'h0000_0010, '0);
    set_req(3, 1, 0, 32'h0000_0030, '0);
    @(negedge clk);
    rstn = 1'b1;
    ptr = 0;
    run_txn(0, 0, $urandom, w);
    check("rst_first_winner", w, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
